// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging N_REQ valid/ready requesters onto one
// registered downstream valid/ready channel, with a transfer counter.
module handshake_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    input  logic                    m_ready,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        xfer_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              acc;
    logic              xfer;
    logic              up_xfer;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   idx;
    int                idx_int;
    logic [DATA_W-1:0] data_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_a[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign xfer = m_valid_q && m_ready;
    assign acc  = (state_q == IDLE) || xfer;

    // Scan starts just past the last grantee so it has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx_int   = 0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_int = (int'(last_q) + k) % N_REQ;
            idx     = ID_W'(idx_int);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (acc && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign up_xfer = acc && win_found;

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A new beat loaded on a drain cycle keeps the stage full.
        if (up_xfer) begin
            m_data_d  = data_a[win_id];
            grant_d   = win_id;
            last_d    = win_id;
            m_valid_d = 1'b1;
            state_d   = SEND;
        end else if (xfer) begin
            m_valid_d = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            grant_q   <= '0;
            last_q    <= ID_W'(N_REQ - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign grant_id   = grant_q;
    assign busy       = m_valid_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter: directed scenarios
// plus randomized traffic against a round-robin reference model.
module tb_handshake_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [1:0]    grant_id;
    logic          busy;
    logic [CW-1:0] xfer_count;

    int checks;
    int errors;

    handshake_rr_arbiter #(
        .N_REQ (N),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        m_ready   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        m_ready   = 1'b0;
        #2;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b/%b want 0/0", m_valid, busy);
        end
        checks++;
        if (m_data !== 8'h00 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%0d want 00/0", m_data, grant_id);
        end
        checks++;
        if (xfer_count !== 4'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%b want 0/0000", xfer_count, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_beat();
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        m_ready   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_beat: got v%b d%h g%0d want v1 dA5 g0", m_valid, m_data, grant_id);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || xfer_count !== 4'd1) begin
            errors++;
            $display("FAIL single_done: got v%b c%0d want v0 c1", m_valid, xfer_count);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [5];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        m_ready   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || grant_id !== seq[k] || m_data !== (8'h10 + 8'(seq[k]))) begin
                errors++;
                $display("FAIL rr_seq%0d: got v%b g%0d d%h want v1 g%0d", k, m_valid, grant_id, m_data, seq[k]);
            end
            checks++;
            if (xfer_count !== 4'(k)) begin
                errors++;
                $display("FAIL rr_cnt%0d: got %0d want %0d", k, xfer_count, k);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h003C_0000;
        m_ready   = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_first_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0055;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h3C || grant_id !== 2'd2 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d: got v%b d%h g%0d r%b want v1 d3C g2 r0000", k, m_valid, m_data, grant_id, req_ready);
            end
            tick();
        end
        checks++;
        if (xfer_count !== 4'd0) begin
            errors++;
            $display("FAIL bp_nocount: got %0d want 0", xfer_count);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        checks++;
        if (xfer_count !== 4'd1 || m_data !== 8'h55 || grant_id !== 2'd0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got c%0d d%h g%0d v%b want c1 d55 g0 v1", xfer_count, m_data, grant_id, m_valid);
        end
        tick();
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_B1A0;
        m_ready   = 1'b1;
        tick();
        req_valid = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (req_ready !== ((k % 2 == 0) ? 4'b0001 : 4'b0010)) begin
                errors++;
                $display("FAIL fair_ready%0d: got %b want %b", k, req_ready, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            end
            tick();
            checks++;
            if (grant_id !== 2'(k % 2) || m_data !== ((k % 2 == 0) ? 8'hA0 : 8'hB1)) begin
                errors++;
                $display("FAIL fair_grant%0d: got g%0d d%h want g%0d", k, grant_id, m_data, k % 2);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_7700;
        m_ready   = 1'b1;
        repeat (3) tick();
        m_ready   = 1'b0;
        tick();
        req_valid = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || xfer_count !== 4'd0) begin
            errors++;
            $display("FAIL async_rst: got v%b b%b c%0d want v0 b0 c0", m_valid, busy, xfer_count);
        end
        #1;
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        m_ready   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL async_first_ready: got %b want 0001", req_ready);
        end
        tick();
        checks++;
        if (grant_id !== 2'd0 || m_data !== 8'h11 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_first_grant: got g%0d d%h want g0 d11", grant_id, m_data);
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0042;
        m_ready   = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            checks++;
            if (xfer_count !== 4'((k - 1) % 16)) begin
                errors++;
                $display("FAIL wrap_cnt%0d: got %0d want %0d", k, xfer_count, (k - 1) % 16);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        bit            full;
        logic [DW-1:0] mdata;
        int            mid;
        int            mlast;
        int            mcnt;
        bit            pend  [N];
        logic [DW-1:0] pdata [N];
        int            waitc [N];
        int            w;
        bit            acc;
        bit            out;
        logic [N-1:0]  exp_ready;
        do_reset();
        full  = 1'b0;
        mdata = '0;
        mid   = 0;
        mlast = N - 1;
        mcnt  = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
            waitc[i] = 0;
        end
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    pdata[i] = DW'($urandom);
                    waitc[i] = 0;
                end
                req_valid[i]           = pend[i];
                req_data[i*DW +: DW]   = pdata[i];
            end
            m_ready = ($urandom_range(0, 9) < 7);
            #1;
            w         = pick(req_valid, mlast);
            acc       = !full || m_ready;
            exp_ready = '0;
            if (acc && w >= 0) exp_ready[w] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            @(posedge clk);
            out = full && m_ready;
            if (out) mcnt = (mcnt + 1) % 16;
            if (acc && w >= 0) begin
                checks++;
                if (waitc[w] > N - 1) begin
                    errors++;
                    $display("FAIL rnd_fair c%0d: req %0d waited %0d grants", c, w, waitc[w]);
                end
                for (int i = 0; i < N; i++) begin
                    if (pend[i] && i != w) waitc[i]++;
                end
                full    = 1'b1;
                mdata   = pdata[w];
                mid     = w;
                mlast   = w;
                pend[w] = 1'b0;
            end else if (out) begin
                full = 1'b0;
            end
            #1;
            checks++;
            if (m_valid !== full || busy !== full || xfer_count !== 4'(mcnt)) begin
                errors++;
                $display("FAIL rnd_state c%0d: got v%b b%b c%0d want v%b c%0d", c, m_valid, busy, xfer_count, full, mcnt);
            end
            if (full) begin
                checks++;
                if (m_data !== mdata || grant_id !== 2'(mid)) begin
                    errors++;
                    $display("FAIL rnd_beat c%0d: got d%h g%0d want d%h g%0d", c, m_data, grant_id, mdata, mid);
                end
            end
        end
        req_valid = '0;
        m_ready   = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        m_ready   = 1'b0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_rr_arbiter.md
Name:
handshake_rr_arbiter

Overview:
- Shares one downstream valid/ready channel between N_REQ upstream valid/ready requesters.
- Uses round-robin arbitration and a registered output stage.
- Sits between several handshake masters and a single AXI4-Lite-style slave channel.
- Sustains one transfer per cycle when the downstream is always ready.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, payload width per requester
CNT_W, 16, width of completed-transfer counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester valid
req_data  input  N_REQ*DATA_W  per-requester payload, requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  per-requester ready (combinational, one-hot or zero)
m_valid  output  1  downstream valid (registered)
m_data  output  DATA_W  downstream payload (registered)
m_ready  input  1  downstream ready
grant_id  output  $clog2(N_REQ)  index of requester whose data is in m_data (registered)
busy  output  1  high while m_valid is high
xfer_count  output  CNT_W  completed downstream handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous on rst high; release synchronous to clk):
  - m_valid=0, m_data=0, grant_id=0, xfer_count=0, state=IDLE.
  - last pointer = N_REQ-1, so requester 0 has highest priority first.
- States:
  - IDLE: output register empty.
  - SEND: output register holds one beat.
- Accept window `acc` = (state==IDLE) or (m_valid and m_ready).
- Arbitration (combinational):
  - Winner = first i with req_valid[i]=1, scanning last+1, last+2, ... mod N_REQ.
  - req_ready[winner]=1 only when acc=1; all other req_ready bits are 0.
  - req_ready never depends on req_valid of the same requester beyond selection.
  - No requester is ever readied when no req_valid is set.
- Upstream transfer on req_valid[i] and req_ready[i] at a rising edge:
  - m_data <= req_data[i], grant_id <= i, last <= i, m_valid <= 1, state <= SEND.
- Downstream transfer on m_valid and m_ready:
  - xfer_count increments by 1.
  - If an upstream transfer occurs in the same cycle: state stays SEND and m_valid stays 1 with the new beat (back-to-back, no bubble).
  - Otherwise: m_valid <= 0, state <= IDLE.
- Stability: in SEND with m_ready=0, m_valid, m_data and grant_id hold unchanged, and req_ready is all zero.
- Latency: a req_valid seen in IDLE appears on m_valid the next cycle.
- Fairness:
  - A continuously requesting requester is served within N_REQ downstream handshakes.
  - The last grantee has lowest priority for the next arbitration.
- Requester contract (checked by the bench, not by the RTL): once req_valid is raised, it and req_data stay stable until req_ready.
- Counter: xfer_count wraps from 2^CNT_W-1 to 0 without flagging.
- Reset mid-operation: an in-flight beat is discarded, m_valid drops immediately (asynchronously), and no handshake is counted.
- Single requester asserting: that requester is granted every accept window regardless of the pointer.
- m_ready held high while m_valid=0 has no effect.

Test Plan:
1. Reset then single beat:
   - Stimulus: rst pulse; req_valid=4'b0001, req_data[0]=8'hA5, m_ready=1.
   - Response: req_ready=4'b0001 in cycle 0; m_valid=1, m_data=A5, grant_id=0 in cycle 1; xfer_count=1 after cycle 1; m_valid=0 in cycle 2.
2. Round-robin, all requesting:
   - Stimulus: req_valid=4'b1111 with data 8'h10,8'h11,8'h12,8'h13; m_ready=1.
   - Response: grant_id sequence 0,1,2,3,0 on consecutive cycles; m_valid continuously 1; xfer_count=4 after four beats.
3. Backpressure:
   - Stimulus: m_ready=0 for 5 cycles with beat 8'h3C from requester 2 pending.
   - Response: m_data=3C and grant_id=2 stable; req_ready=0 throughout; one count once m_ready=1.
4. Fairness after grant:
   - Stimulus: last=1; req_valid=4'b0011.
   - Response: requester 0 is granted next, then requester 1, alternating.
5. Asynchronous reset mid-SEND:
   - Stimulus: assert rst between clock edges while m_valid=1 with m_ready=0.
   - Response: m_valid=0 and xfer_count=0 before the next edge; first grant after release goes to requester 0.
6. Counter wrap:
   - Stimulus: CNT_W=4; 17 back-to-back handshakes.
   - Response: xfer_count reads 15 then 0 then 1.
